// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, execute (redirect) and decode.
// Latency: none, wires only.
// Backpressure: imem_req_ready and id_ready flow into the fetch unit. The response path has no backpressure.
// Ports: imem_req_* (request out), imem_rsp_* (response in), redirect_* (from execute), id_* (to decode).
// master: the fetch unit's view of the bundle. slave: the view of its surroundings.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It owns the PC, keeps up to 2 imem requests in flight, and buffers responses for decode.
// Latency: a response at edge t is visible on id_* in cycle t+1. Fetch-to-decode latency is at least 2 cycles.
// Backpressure: requests stop when in-flight + owed + buffered entries reach 2, so a decode stall never overflows.
// Ports: clk, rst_n (async, active-low), and bus (fetch_unit_if.master) carrying imem req/rsp, redirect and id.
module fetch_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    // Program counter.
    logic [XLEN-1:0] pc_q, pc_d;

    // In-flight request addresses: a 2-deep circular queue.
    logic [XLEN-1:0] inf_addr_q [2];
    logic [XLEN-1:0] inf_addr_d [2];
    logic            inf_head_q, inf_head_d;
    logic [1:0]      inf_cnt_q, inf_cnt_d;

    // Responses still owed for requests that a redirect flushed.
    logic [1:0]      drop_cnt_q, drop_cnt_d;

    // Output buffer of {pc, instr}: a 2-deep circular queue.
    logic [XLEN-1:0] fifo_pc_q [2];
    logic [XLEN-1:0] fifo_pc_d [2];
    logic [XLEN-1:0] fifo_instr_q [2];
    logic [XLEN-1:0] fifo_instr_d [2];
    logic            fifo_head_q, fifo_head_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;

    logic            id_vld;
    logic            pop;
    logic            req_vld;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_take;
    logic [2:0]      credit_used;
    logic [2:0]      owed;
    logic            inf_tail;
    logic            fifo_tail;

    always_comb begin
        id_vld = (fifo_cnt_q != 2'd0) && !bus.redirect_valid;
        pop    = id_vld && bus.id_ready;

        // Every entry in flight, owed or buffered holds one of the two slots.
        // An entry that decode pops this cycle frees its slot at once, so a full pipe keeps streaming.
        credit_used = {1'b0, inf_cnt_q} + {1'b0, drop_cnt_q} + {1'b0, fifo_cnt_q} - {2'b00, pop};
        req_vld     = rst_n && !bus.redirect_valid && (credit_used < 3'd2);
        req_fire    = req_vld && bus.imem_req_ready;

        rsp_drop = bus.imem_rsp_valid && (drop_cnt_q != 2'd0);
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_take = bus.imem_rsp_valid && (drop_cnt_q == 2'd0) && (inf_cnt_q != 2'd0);

        // The tail slot is head + count, taken modulo 2.
        inf_tail  = inf_head_q ^ inf_cnt_q[0];
        fifo_tail = fifo_head_q ^ fifo_cnt_q[0];

        owed = {1'b0, inf_cnt_q} + {1'b0, drop_cnt_q};

        pc_d         = pc_q;
        inf_addr_d   = inf_addr_q;
        inf_head_d   = inf_head_q;
        inf_cnt_d    = inf_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        fifo_head_d  = fifo_head_q;
        fifo_cnt_d   = fifo_cnt_q;

        if (bus.redirect_valid) begin
            // Everything in flight becomes owed. A response arriving now settles one of those debts.
            if (bus.imem_rsp_valid && (owed != 3'd0)) begin
                owed = owed - 3'd1;
            end
            drop_cnt_d  = owed[1:0];
            inf_cnt_d   = 2'd0;
            inf_head_d  = 1'b0;
            fifo_cnt_d  = 2'd0;
            fifo_head_d = 1'b0;
            pc_d        = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - 2'd1;
            end

            if (rsp_take) begin
                fifo_pc_d[fifo_tail]    = inf_addr_q[inf_head_q];
                fifo_instr_d[fifo_tail] = bus.imem_rsp_data;
                inf_head_d              = ~inf_head_q;
            end
            if (pop) begin
                fifo_head_d = ~fifo_head_q;
            end
            fifo_cnt_d = fifo_cnt_q + {1'b0, rsp_take} - {1'b0, pop};

            if (req_fire) begin
                inf_addr_d[inf_tail] = pc_q;
                pc_d                 = pc_q + XLEN'(4);
            end
            inf_cnt_d = inf_cnt_q + {1'b0, req_fire} - {1'b0, rsp_take};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inf_head_q  <= 1'b0;
            inf_cnt_q   <= 2'd0;
            drop_cnt_q  <= 2'd0;
            fifo_head_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                inf_addr_q[i]   <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            inf_addr_q   <= inf_addr_d;
            inf_head_q   <= inf_head_d;
            inf_cnt_q    <= inf_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_head_q  <= fifo_head_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_vld;
    assign bus.id_instr       = fifo_instr_q[fifo_head_q];
    assign bus.id_pc          = fifo_pc_q[fifo_head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit.
// The reference model uses queues for in-flight requests and buffered instructions.
// The memory model answers every accepted request in order after a random latency of at least 1 cycle.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_inf [$];
    int          m_drop;
    logic [63:0] m_fifo [$];

    // Memory model state.
    logic [31:0] mem_addr_q [$];
    int          mem_due_q [$];

    // Stimulus knobs.
    int          pct_rdy, pct_idr, pct_redir, lat_lo, lat_hi;
    logic        force_redir;
    logic [31:0] force_pc;
    logic        rst_drive;

    int cyc;
    int n_vec;
    int n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_00F3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_drop = 0;
        m_inf.delete();
        m_fifo.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
    endtask

    // Drives one cycle of inputs, checks the outputs, then advances the model past the next rising edge.
    task automatic step();
        logic        redir, rdy, idr, rspv, pop, exp_idv, exp_reqv;
        logic [31:0] rpc, rdata, tmp;
        int          used, owed;

        @(negedge clk);
        rst_n = rst_drive;
        if (!rst_drive) model_reset();

        rdy   = ($urandom_range(99) < pct_rdy);
        idr   = ($urandom_range(99) < pct_idr);
        redir = rst_drive && (force_redir || ($urandom_range(99) < pct_redir));
        if (force_redir)              rpc = force_pc;
        else if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(15);
        else                          rpc = $urandom;

        rspv  = 1'b0;
        rdata = $urandom;
        if (rst_drive && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            rspv  = 1'b1;
            rdata = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end

        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rdata;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.id_ready       = idr;

        #1;
        exp_idv  = (m_fifo.size() != 0) && !redir;
        pop      = exp_idv && idr;
        used     = m_inf.size() + m_drop + m_fifo.size() - (pop ? 1 : 0);
        exp_reqv = rst_drive && !redir && (used < 2);

        check_eq("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_reqv});
        check_eq("req_addr", bus.imem_req_addr, m_pc);
        check_eq("id_valid", {31'b0, bus.id_valid}, {31'b0, exp_idv});
        if (exp_idv) begin
            check_eq("id_pc", bus.id_pc, m_fifo[0][63:32]);
            check_eq("id_instr", bus.id_instr, m_fifo[0][31:0]);
        end
        if (!rst_drive) begin
            check_eq("rst_id_pc", bus.id_pc, 32'h0);
            check_eq("rst_id_instr", bus.id_instr, 32'h0);
        end

        if (rst_drive) begin
            if (redir) begin
                owed = m_inf.size() + m_drop;
                if (rspv && owed > 0) owed--;
                m_drop = owed;
                m_inf.delete();
                m_fifo.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                if (pop) void'(m_fifo.pop_front());
                if (rspv) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else if (m_inf.size() > 0) begin
                        tmp = m_inf.pop_front();
                        m_fifo.push_back({tmp, rdata});
                    end
                end
                if (exp_reqv && rdy) begin
                    m_inf.push_back(m_pc);
                    mem_addr_q.push_back(m_pc);
                    mem_due_q.push_back(cyc + lat_lo + int'($urandom_range(lat_hi - lat_lo)));
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic set_knobs(input int r, input int i, input int d, input int lo, input int hi);
        pct_rdy   = r;
        pct_idr   = i;
        pct_redir = d;
        lat_lo    = lo;
        lat_hi    = hi;
    endtask

    // Redirects once, then waits (bounded) for the first instruction delivered from the new target.
    task automatic redirect_and_expect(input logic [31:0] target, input logic [31:0] want_pc);
        logic found;
        force_redir = 1'b1;
        force_pc    = target;
        step();
        force_redir = 1'b0;
        step();
        check_eq("redir_next_addr", bus.imem_req_addr, want_pc);
        found = bus.id_valid;
        if (found) check_eq("redir_first_pc", bus.id_pc, want_pc);
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (bus.id_valid) begin
                found = 1'b1;
                check_eq("redir_first_pc", bus.id_pc, want_pc);
            end
        end
        check_eq("redir_delivered", {31'b0, found}, 32'd1);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        cyc         = 0;
        force_redir = 1'b0;
        force_pc    = '0;
        rst_drive   = 1'b0;
        rst_n       = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        model_reset();
        set_knobs(100, 100, 0, 1, 1);

        // Reset state.
        repeat (3) step();

        // Streaming at memory latency 1. The PC wraps from FFFF_FFFC to 0.
        rst_drive = 1'b1;
        repeat (20) step();

        // Decode stall for 5 cycles, then release.
        set_knobs(100, 0, 0, 1, 1);
        repeat (5) step();
        check_eq("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        set_knobs(100, 100, 0, 1, 1);
        repeat (10) step();

        // Redirect to 0x103 with two requests in flight (latency 3).
        set_knobs(100, 100, 0, 3, 3);
        repeat (8) step();
        redirect_and_expect(32'h0000_0103, 32'h0000_0100);
        repeat (5) step();

        // Redirect in the same cycle as a response (latency 1 means one arrives every cycle).
        set_knobs(100, 100, 0, 1, 1);
        repeat (6) step();
        redirect_and_expect(32'h0000_0040, 32'h0000_0040);

        // Back-to-back redirects: the last one wins.
        force_redir = 1'b1;
        force_pc    = 32'h0000_2000;
        step();
        redirect_and_expect(32'h0000_3002, 32'h0000_3000);

        // Random traffic.
        set_knobs(70, 70, 4, 1, 4);
        repeat (3000) step();

        // Reset with the FIFO full and a request pending, then restart.
        set_knobs(100, 0, 0, 1, 1);
        repeat (6) step();
        rst_drive = 1'b0;
        step();
        check_eq("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check_eq("midrst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        rst_drive = 1'b1;
        set_knobs(100, 100, 0, 1, 1);
        step();
        check_eq("restart_addr", bus.imem_req_addr, RESET_PC);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
